// File: rtl/urv_dm_arbiter.sv
// Arbitrates a single memory port between the core's data interface and a debug host.
// The core wins by default; a waiting host is guaranteed a slot after g_host_starve_limit core grants.
//
//   state     | meaning
//   IDLE      | no transfer; may grant core or host
//   BUSY_CORE | strobing memory on behalf of the core
//   BUSY_HOST | strobing memory on behalf of the host
module urv_dm_arbiter #(
    parameter int g_host_starve_limit = 4,
    parameter int g_timeout           = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_data_s_i,
    input  logic [3:0]  core_select_i,
    input  logic        core_load_i,
    input  logic        core_store_i,
    output logic        core_stall_req_o,
    output logic        core_done_o,
    output logic        core_err_o,
    output logic [31:0] core_data_l_o,

    input  logic        host_req_i,
    input  logic        host_we_i,
    input  logic [31:0] host_addr_i,
    input  logic [31:0] host_data_i,
    input  logic [3:0]  host_sel_i,
    output logic        host_ack_o,
    output logic        host_err_o,
    output logic [31:0] host_data_o,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic [3:0]  mem_sel_o,
    output logic        mem_load_o,
    output logic        mem_store_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {IDLE, BUSY_CORE, BUSY_HOST} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(g_host_starve_limit);
    localparam logic [7:0] TMO_LAST   = 8'(g_timeout - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, core_data_q, host_data_q;
    logic [3:0]  sel_q;
    logic        we_q;
    logic [7:0]  starve_q, tmo_q;
    logic        core_done_q, core_err_q, host_ack_q, host_err_q;
    logic        core_req, busy, pulse_active;
    logic        grant_core, grant_host, mem_done, mem_abort;

    assign core_req     = core_load_i | core_store_i;
    assign busy         = (state_q != IDLE);
    // No grant at all while a completion pulse is out: the finished requester
    // still holds its request that cycle and must not be served twice.
    assign pulse_active = core_done_q | host_ack_q;

    always_comb begin
        state_d    = state_q;
        grant_core = 1'b0;
        grant_host = 1'b0;
        mem_done   = 1'b0;
        mem_abort  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!pulse_active) begin
                    if (host_req_i && (!core_req || starve_q == STARVE_LIM)) begin
                        grant_host = 1'b1;
                        state_d    = BUSY_HOST;
                    end else if (core_req) begin
                        grant_core = 1'b1;
                        state_d    = BUSY_CORE;
                    end
                end
            end
            BUSY_CORE, BUSY_HOST: begin
                if (mem_ready_i) begin
                    mem_done = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    mem_abort = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= '0;
            core_done_q <= 1'b0;
            core_err_q  <= 1'b0;
            host_ack_q  <= 1'b0;
            host_err_q  <= 1'b0;
            core_data_q <= '0;
            host_data_q <= '0;
        end else begin
            state_q     <= state_d;
            core_done_q <= 1'b0;
            core_err_q  <= 1'b0;
            host_ack_q  <= 1'b0;
            host_err_q  <= 1'b0;

            if (state_q == IDLE && !host_req_i)
                starve_q <= '0;

            if (grant_core) begin
                addr_q  <= core_addr_i;
                wdata_q <= core_data_s_i;
                sel_q   <= core_select_i;
                we_q    <= core_store_i;
                tmo_q   <= '0;
                if (host_req_i && starve_q != 8'hFF)
                    starve_q <= starve_q + 8'd1;
            end
            if (grant_host) begin
                addr_q   <= host_addr_i;
                wdata_q  <= host_data_i;
                sel_q    <= host_sel_i;
                we_q     <= host_we_i;
                tmo_q    <= '0;
                starve_q <= '0;
            end

            if (busy && !mem_ready_i)
                tmo_q <= tmo_q + 8'd1;

            if (mem_done || mem_abort) begin
                if (state_q == BUSY_CORE) begin
                    core_done_q <= 1'b1;
                    core_err_q  <= mem_abort;
                    if (mem_done && !we_q)
                        core_data_q <= mem_data_i;
                end else begin
                    host_ack_q <= 1'b1;
                    host_err_q <= mem_abort;
                    if (mem_done && !we_q)
                        host_data_q <= mem_data_i;
                end
            end
        end
    end

    assign core_stall_req_o = core_req & ~core_done_q;
    assign core_done_o      = core_done_q;
    assign core_err_o       = core_err_q;
    assign core_data_l_o    = core_data_q;
    assign host_ack_o       = host_ack_q;
    assign host_err_o       = host_err_q;
    assign host_data_o      = host_data_q;
    assign mem_addr_o       = addr_q;
    assign mem_data_o       = wdata_q;
    assign mem_sel_o        = sel_q;
    assign mem_load_o       = busy & ~we_q;
    assign mem_store_o      = busy & we_q;

endmodule

// File: tb/tb_urv_dm_arbiter.sv
// Bench for urv_dm_arbiter: directed transfers push expected completions into a
// queue; a negedge monitor pops and compares whenever done/ack pulses.
module tb_urv_dm_arbiter;
    localparam int LIM = 4;
    localparam int TMO = 8;

    logic        clk_i = 1'b0, rst_n_i = 1'b0;
    logic [31:0] core_addr_i = '0, core_data_s_i = '0;
    logic [3:0]  core_select_i = '0;
    logic        core_load_i = 1'b0, core_store_i = 1'b0;
    logic        core_stall_req_o, core_done_o, core_err_o;
    logic [31:0] core_data_l_o;
    logic        host_req_i = 1'b0, host_we_i = 1'b0;
    logic [31:0] host_addr_i = '0, host_data_i = '0;
    logic [3:0]  host_sel_i = '0;
    logic        host_ack_o, host_err_o;
    logic [31:0] host_data_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic [3:0]  mem_sel_o;
    logic        mem_load_o, mem_store_o;
    logic        mem_ready_i = 1'b0;
    logic [31:0] mem_data_i = '0;

    urv_dm_arbiter #(.g_host_starve_limit(LIM), .g_timeout(TMO)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .core_addr_i(core_addr_i), .core_data_s_i(core_data_s_i), .core_select_i(core_select_i),
        .core_load_i(core_load_i), .core_store_i(core_store_i),
        .core_stall_req_o(core_stall_req_o), .core_done_o(core_done_o), .core_err_o(core_err_o),
        .core_data_l_o(core_data_l_o),
        .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_data_i(host_data_i), .host_sel_i(host_sel_i),
        .host_ack_o(host_ack_o), .host_err_o(host_err_o), .host_data_o(host_data_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_sel_o(mem_sel_o),
        .mem_load_o(mem_load_o), .mem_store_o(mem_store_o),
        .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          host;
        bit          err;
        logic [31:0] data;
        logic [31:0] addr;
        int          strobes;
        bit          store;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          vectors = 0, miscompares = 0;
    int          wait_cycles = 0, run_len = 0, last_len = 0, done_seen = 0;
    bit          stuck = 1'b0, ready_idle = 1'b0, run_store = 1'b0;
    logic [31:0] rdata = '0, run_addr = '0;
    logic [31:0] exp_core = '0, exp_host = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Strobe tracking, completion monitor and memory responder.
    always @(negedge clk_i) begin
        if (mem_load_o && mem_store_o) begin
            miscompares++;
            $display("FAIL strobe_excl: got load=1 store=1 expected one-hot");
        end
        if (mem_load_o || mem_store_o) begin
            if (run_len == 0) begin
                run_addr  = mem_addr_o;
                run_store = mem_store_o;
            end else if (mem_addr_o !== run_addr || mem_store_o !== run_store) begin
                miscompares++;
                $display("FAIL strobe_stable: got addr 0x%08h expected 0x%08h", mem_addr_o, run_addr);
            end
            run_len++;
        end else if (run_len != 0) begin
            last_len = run_len;
            run_len  = 0;
        end

        if (core_done_o || host_ack_o) begin
            done_seen++;
            if (core_done_o && host_ack_o) begin
                miscompares++;
                $display("FAIL dual_done: got core_done=1 host_ack=1 expected one");
            end
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: got completion expected none");
            end else begin
                mon_e = sb.pop_front();
                chk("owner", {31'd0, host_ack_o}, {31'd0, mon_e.host});
                chk("err", {31'd0, mon_e.host ? host_err_o : core_err_o}, {31'd0, mon_e.err});
                chk("data", mon_e.host ? host_data_o : core_data_l_o, mon_e.data);
                chk("addr", run_addr, mon_e.addr);
                chk("strobes", 32'(last_len), 32'(mon_e.strobes));
                chk("dir", {31'd0, run_store}, {31'd0, mon_e.store});
            end
        end

        if (mem_load_o || mem_store_o) begin
            mem_ready_i = !stuck && (run_len - 1 == wait_cycles);
            mem_data_i  = rdata;
        end else begin
            mem_ready_i = ready_idle;
            mem_data_i  = 32'hBAD0_BAD0;
        end
    end

    task automatic core_xfer(input logic [31:0] a, input bit ld, input bit st, input logic [31:0] wd,
                             input int wt, input bit stk, input logic [31:0] rd,
                             input int exp_strobes, input int exp_lat);
        exp_t e;
        int   lat = 0;
        bit   got = 0;
        if (!st && !stk) exp_core = rd;
        e.host = 0; e.err = stk; e.data = exp_core; e.addr = a; e.strobes = exp_strobes; e.store = st;
        sb.push_back(e);
        wait_cycles = wt; stuck = stk; rdata = rd;
        core_addr_i = a; core_data_s_i = wd; core_select_i = 4'hF;
        core_load_i = ld; core_store_i = st;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk_i);
            lat++;
            if (lat == 1) chk("core_stall", {31'd0, core_stall_req_o}, 32'd1);
            if (lat == 2) chk("core_wdata", mem_data_o, wd);
            if (core_done_o) got = 1;
        end
        if (!got) begin
            miscompares++;
            $display("FAIL core_timeout: got no core_done_o expected one within 300 cycles");
        end else begin
            chk("core_latency", 32'(lat), 32'(exp_lat));
            chk("stall_at_done", {31'd0, core_stall_req_o}, 32'd0);
        end
        @(posedge clk_i); #1;
        core_load_i = 0; core_store_i = 0; stuck = 0;
    endtask

    task automatic host_xfer(input logic [31:0] a, input bit we, input logic [31:0] wd, input logic [3:0] sel,
                             input int wt, input logic [31:0] rd, input int exp_strobes, input int exp_lat);
        exp_t e;
        int   lat = 0;
        bit   got = 0;
        if (!we) exp_host = rd;
        e.host = 1; e.err = 0; e.data = exp_host; e.addr = a; e.strobes = exp_strobes; e.store = we;
        sb.push_back(e);
        wait_cycles = wt; stuck = 0; rdata = rd;
        host_addr_i = a; host_we_i = we; host_data_i = wd; host_sel_i = sel; host_req_i = 1;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk_i);
            lat++;
            if (lat == 2) begin
                chk("host_wdata", mem_data_o, wd);
                chk("host_sel", {28'd0, mem_sel_o}, {28'd0, sel});
            end
            if (host_ack_o) got = 1;
        end
        if (!got) begin
            miscompares++;
            $display("FAIL host_timeout: got no host_ack_o expected one within 300 cycles");
        end else
            chk("host_latency", 32'(lat), 32'(exp_lat));
        @(posedge clk_i); #1;
        host_req_i = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   seen0, cnt;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mem_load", {31'd0, mem_load_o}, 32'd0);
        chk("rst_mem_store", {31'd0, mem_store_o}, 32'd0);
        chk("rst_done_err", {28'd0, core_done_o, core_err_o, host_ack_o, host_err_o}, 32'd0);
        chk("rst_core_data", core_data_l_o, 32'd0);
        chk("rst_host_data", host_data_o, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        @(negedge clk_i) rst_n_i = 1;
        @(posedge clk_i); #1;

        // Basic core load, first-cycle ready.
        core_xfer(32'h0000_1004, 1, 0, 32'h0, 0, 0, 32'hDEAD_BEEF, 1, 3);
        repeat (3) @(posedge clk_i);
        #1 chk("core_data_hold", core_data_l_o, 32'hDEAD_BEEF);

        // Host store with three wait states, then host load.
        host_xfer(32'h0000_2000, 1, 32'h1234_5678, 4'hF, 3, 32'h0, 4, 6);
        host_xfer(32'h0000_2004, 0, 32'h0, 4'h3, 1, 32'hCAFE_F00D, 2, 4);

        // Load and store together is a store.
        core_xfer(32'h0000_3000, 1, 1, 32'hA5A5_A5A5, 0, 0, 32'h1111_1111, 1, 3);

        // Timeout abort, then ready on the final permitted cycle.
        core_xfer(32'h0000_4000, 1, 0, 32'h0, 0, 1, 32'h9999_9999, TMO, TMO + 2);
        core_xfer(32'h0000_5000, 1, 0, 32'h0, TMO - 1, 0, 32'h0000_00A5, TMO, TMO + 2);

        // Ready asserted while idle must do nothing.
        seen0 = done_seen;
        ready_idle = 1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("idle_ready_ignored", 32'(done_seen - seen0), 32'd0);
        chk("idle_no_strobe", {30'd0, mem_load_o, mem_store_o}, 32'd0);
        chk("idle_data_kept", core_data_l_o, 32'h0000_00A5);
        ready_idle = 0;

        // Core drops its request mid-transfer; completion still occurs.
        exp_core = 32'h0000_0077;
        e.host = 0; e.err = 0; e.data = exp_core; e.addr = 32'h0000_6000; e.strobes = 3; e.store = 0;
        sb.push_back(e);
        wait_cycles = 2; rdata = 32'h0000_0077;
        core_addr_i = 32'h0000_6000; core_load_i = 1;
        @(posedge clk_i); #1;
        core_load_i = 0;
        cnt = 0;
        for (int i = 0; i < 50 && cnt == 0; i++) begin
            @(negedge clk_i);
            if (core_done_o) cnt = 1;
        end
        chk("dropped_req_done", 32'(cnt), 32'd1);
        @(posedge clk_i); #1;

        // Both requesting continuously: C,C,C,C,H,C,C,C,C,H.
        rdata = 32'h5A5A_5A5A; wait_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            e.host = (i % 5 == 4); e.err = 0; e.data = 32'h5A5A_5A5A;
            e.addr = e.host ? 32'h0000_0200 : 32'h0000_0100; e.strobes = 1; e.store = 0;
            sb.push_back(e);
        end
        core_addr_i = 32'h0000_0100; core_load_i = 1; core_store_i = 0;
        host_addr_i = 32'h0000_0200; host_we_i = 0; host_req_i = 1;
        cnt = 0;
        for (int i = 0; i < 200 && cnt < 10; i++) begin
            @(negedge clk_i);
            if (core_done_o || host_ack_o) cnt++;
        end
        chk("arb_completions", 32'(cnt), 32'd10);
        @(posedge clk_i); #1;
        core_load_i = 0; host_req_i = 0;
        exp_core = 32'h5A5A_5A5A; exp_host = 32'h5A5A_5A5A;
        repeat (2) @(posedge clk_i);
        #1 chk("arb_sb_drained", 32'(sb.size()), 32'd0);

        // Reset in the second BUSY cycle of a host transfer.
        stuck = 1;
        host_addr_i = 32'h0000_7000; host_we_i = 0; host_req_i = 1;
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_n_i = 0;
        #1;
        chk("rst_mid_strobes", {30'd0, mem_load_o, mem_store_o}, 32'd0);
        chk("rst_mid_ack", {31'd0, host_ack_o}, 32'd0);
        chk("rst_mid_data", host_data_o | core_data_l_o | mem_addr_o, 32'd0);
        exp_core = 32'h0; exp_host = 32'h3131_3131;
        e.host = 1; e.err = 0; e.data = exp_host; e.addr = 32'h0000_7000; e.strobes = 1; e.store = 0;
        sb.push_back(e);
        stuck = 0; wait_cycles = 0; rdata = 32'h3131_3131;
        @(negedge clk_i) rst_n_i = 1;
        @(posedge clk_i); #1;
        chk("regrant_after_rst", {31'd0, mem_load_o}, 32'd1);
        cnt = 0;
        for (int i = 0; i < 50 && cnt == 0; i++) begin
            @(negedge clk_i);
            if (host_ack_o) cnt = 1;
        end
        chk("regrant_ack", 32'(cnt), 32'd1);
        @(posedge clk_i); #1;
        host_req_i = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("final_core_data", core_data_l_o, exp_core);
        chk("final_host_data", host_data_o, exp_host);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
